// File: rtl/cipher_pkg.sv
// Shared types and helpers for the multi-key stream cipher engine.
package cipher_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ROT_W_DEF  = 5;
  localparam logic [63:0] MOD_P_DEF  = 64'd4294967311;

  typedef enum logic {
    MODE_ROTXOR = 1'b0,
    MODE_SQMOD  = 1'b1
  } mode_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  err;
  } fifo_entry_t;

  // Rotate through a doubled word so r=0 never turns into a shift by the full width.
  function automatic logic [DATA_W_DEF-1:0] rotl(input logic [DATA_W_DEF-1:0] v,
                                                 input logic [ROT_W_DEF-1:0]  r);
    logic [2*DATA_W_DEF-1:0] dbl;
    dbl = {v, v} << r;
    return dbl[2*DATA_W_DEF-1:DATA_W_DEF];
  endfunction

endpackage

// File: rtl/cipher_out_fifo.sv
// Show-ahead output FIFO; count feeds the upstream credit check.
module cipher_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop    = pop && (count != '0);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(push && !do_pop && count == CNT_W'(DEPTH)));
  end

endmodule

// File: rtl/cipher_stream_engine.sv
// Multi-key stream cipher: key program/data beats in, S1 key-rotate stage, mix + FIFO out.
module cipher_stream_engine
  import cipher_pkg::*;
#(
  parameter int unsigned         DATA_W     = DATA_W_DEF,
  parameter int unsigned         ROT_W      = ROT_W_DEF,
  parameter int unsigned         NUM_KEYS   = 4,
  parameter int unsigned         KSEL_W     = 2,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter logic [2*DATA_W-1:0] MOD_P      = (2*DATA_W)'(MOD_P_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_prog,
  input  logic [KSEL_W-1:0] in_key_sel,
  input  logic              in_mode,
  input  logic [ROT_W-1:0]  in_rot,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0]   keys [NUM_KEYS];
  logic [NUM_KEYS-1:0] kvalid;
  logic                ready_en;
  logic                accept;

  logic                s1_valid;
  logic [DATA_W-1:0]   s1_krot;
  logic [DATA_W-1:0]   s1_data;
  mode_e               s1_mode;
  logic                s1_err;

  logic [DATA_W-1:0]   k_sel;
  logic [ROT_W-1:0]    r_sel;
  logic [2*DATA_W-1:0] sq;
  logic [DATA_W-1:0]   mix;
  fifo_entry_t         push_entry;
  fifo_entry_t         head_entry;
  logic [CNT_W-1:0]    fifo_count;
  logic                credit_ok;

  // ready_en holds in_ready low for the first cycle out of reset.
  always_comb begin
    credit_ok = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid}) < (CNT_W + 1)'(FIFO_DEPTH);
    in_ready  = ready_en && credit_ok;
    accept    = in_valid && in_ready;
  end

  always_comb begin
    k_sel = keys[in_key_sel];
    r_sel = in_rot;
    if (mode_e'(in_mode) == MODE_SQMOD) r_sel = k_sel[ROT_W-1:0] ^ in_rot;
  end

  always_ff @(posedge clk) begin
    if (accept && in_prog) keys[in_key_sel] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kvalid   <= '0;
      s1_valid <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      s1_valid <= accept && !in_prog;
      if (accept && in_prog) kvalid[in_key_sel] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !in_prog) begin
      s1_krot <= rotl(k_sel, r_sel);
      s1_data <= in_data;
      s1_mode <= mode_e'(in_mode);
      s1_err  <= ~kvalid[in_key_sel];
    end
  end

  always_comb begin
    sq  = {{DATA_W{1'b0}}, s1_krot} * {{DATA_W{1'b0}}, s1_krot};
    mix = s1_krot;
    if (s1_mode == MODE_SQMOD) mix = DATA_W'(sq % MOD_P);
    push_entry.err  = s1_err;
    push_entry.data = s1_err ? s1_data : (s1_data ^ mix);
  end

  cipher_out_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid),
    .push_data (push_entry),
    .pop       (out_valid && out_ready),
    .head_data (head_entry),
    .count     (fifo_count)
  );

  always_comb begin
    out_valid = (fifo_count != '0);
    out_data  = out_valid ? head_entry.data : '0;
    out_err   = out_valid ? head_entry.err : 1'b0;
  end

endmodule

// File: tb/tb_cipher_stream_engine.sv
// Scoreboard bench for cipher_stream_engine: driver queues expectations, monitor checks outputs.
module tb_cipher_stream_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_prog;
  logic [1:0]  in_key_sel;
  logic        in_mode;
  logic [4:0]  in_rot;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  always #5 clk = ~clk;

  cipher_stream_engine #(
    .DATA_W     (32),
    .ROT_W      (5),
    .NUM_KEYS   (4),
    .KSEL_W     (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_prog    (in_prog),
    .in_key_sel (in_key_sel),
    .in_mode    (in_mode),
    .in_rot     (in_rot),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_err    (out_err)
  );

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cycles[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every output transfer pops one expectation.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data 0x%0h err %0b expected none", out_data, out_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", {32'h0, out_data}, {32'h0, e.data});
        check("out_err", {63'h0, out_err}, {63'h0, e.err});
        pop_cycles.push_back(cycle);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input bit prog, input int sel, input bit mode, input int rot,
                      input logic [31:0] data, input logic [31:0] ed, input bit ee);
    int waited;
    waited     = 0;
    in_valid   = 1'b1;
    in_prog    = prog;
    in_key_sel = 2'(sel);
    in_mode    = mode;
    in_rot     = 5'(rot);
    in_data    = data;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready 0 expected 1");
    end else if (!prog) begin
      exp_q.push_back('{data: ed, err: ee});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_prog  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  int accepted;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_prog = 1'b0; in_key_sel = '0;
    in_mode = 1'b0; in_rot = '0; in_data = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'h0, out_valid}, 64'd0);
    check("rst_out_data", {32'h0, out_data}, 64'd0);
    check("rst_out_err", {63'h0, out_err}, 64'd0);
    check("rst_in_ready", {63'h0, in_ready}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'h0, in_ready}, 64'd0);
    check("post_rst_out_valid", {63'h0, out_valid}, 64'd0);
    @(posedge clk); #1;

    // Never-programmed slot: plaintext passes, flagged.
    send(0, 2, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 1);
    idle();
    drain("drain_unprog");

    // Rotate-XOR with two-cycle latency.
    send(1, 0, 0, 0, 32'h80000001, '0, 0);
    send(0, 0, 0, 1, 32'hA5A5A5A5, 32'hA5A5A5A6, 0);
    idle();
    @(negedge clk);
    check("lat_edge_T", {63'h0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge_T1", {63'h0, out_valid}, 64'd1);
    @(posedge clk); #1;
    drain("drain_rotxor");

    // Square-mod mode, rot 0, and rotation by 31.
    send(1, 1, 0, 0, 32'h00000001, '0, 0);
    send(0, 1, 1, 0, 32'h00000000, 32'h00000004, 0);
    send(1, 3, 0, 0, 32'h12345678, '0, 0);
    send(0, 3, 0, 0, 32'h00000000, 32'h12345678, 0);
    send(0, 0, 0, 31, 32'h00000000, 32'hC0000000, 0);
    send(1, 2, 0, 0, 32'hFFFFFFFF, '0, 0);
    // (2^32-1)^2 mod (2^32+15) = (-16)^2 = 256
    send(0, 2, 1, 31, 32'h00000000, 32'h00000100, 0);
    idle();
    drain("drain_modes");

    // Backpressure: only FIFO_DEPTH beats fit.
    out_ready = 1'b0;
    accepted  = 0;
    in_valid = 1'b1; in_prog = 1'b0; in_key_sel = 2'd3; in_mode = 1'b0; in_rot = '0;
    for (int i = 0; i < 10; i++) begin
      in_data = 32'h100 + 32'(accepted);
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back('{data: in_data ^ 32'h12345678, err: 1'b0});
        accepted++;
      end
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    check("bp_accepted", 64'(accepted), 64'd4);
    check("bp_in_ready", {63'h0, in_ready}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    drain("drain_bp");
    @(negedge clk);
    check("bp_recover", {63'h0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // 16-beat stream at one beat per clock.
    pop_cycles.delete();
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = 32'hCAFE0000 + 32'(i * 3);
      send(0, 3, 0, 0, d, d ^ 32'h12345678, 0);
    end
    idle();
    drain("drain_stream");
    check("stream_count", 64'(pop_cycles.size()), 64'd16);
    if (pop_cycles.size() == 16)
      check("stream_span", 64'(pop_cycles[15] - pop_cycles[0]), 64'd15);

    // Reprogram right after a data beat.
    send(0, 0, 0, 0, 32'h11111111, 32'h91111110, 0);
    send(1, 0, 0, 0, 32'h0000FFFF, '0, 0);
    send(0, 0, 0, 0, 32'h11111111, 32'h1111EEEE, 0);
    idle();
    drain("drain_reprog");

    // Reset with beats queued discards them and invalidates keys.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(0, 3, 0, 0, 32'(i), '0, 0);
    idle();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    check("midrst_out_data", {32'h0, out_data}, 64'd0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'd0);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    send(0, 0, 0, 0, 32'h01234567, 32'h01234567, 1);
    send(1, 0, 0, 0, 32'hF0F0F0F0, '0, 0);
    send(0, 0, 0, 0, 32'h00000000, 32'hF0F0F0F0, 0);
    idle();
    drain("drain_midrst");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
